// File: rtl/slice_mon_pkg.sv
// Shared event type and width helpers for the slice change monitor and its FIFO.
package slice_mon_pkg;

  function automatic int chan_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_TS_W     = 16;
  localparam int DEF_CHAN_W   = chan_idx_w(DEF_CHANNELS);

  // Event record at default widths; parametrised instances build a matching local type.
  typedef struct packed {
    logic [DEF_CHAN_W-1:0] chan;
    logic [DEF_WIDTH-1:0]  value;
    logic [DEF_TS_W-1:0]   ts;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous event FIFO: push/full on the write side, valid/ready on the read side.
// A push is accepted while full when a pop happens in the same cycle.
module event_fifo
  import slice_mon_pkg::*;
#(
  parameter type entry_t = event_t,
  parameter int  DEPTH   = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  output logic   full,
  output logic   rd_valid,
  input  logic   rd_ready,
  output entry_t rd_data
);

  localparam int PW = ptr_w(DEPTH);

  entry_t       mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         empty;
  logic         pop;
  logic         do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign do_push  = push && (!full || pop);
  assign rd_data  = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/slice_change_monitor.sv
// Multi-channel masked change monitor: detects bit-slice changes per channel and
// streams timestamped events through a valid/ready FIFO.
module slice_change_monitor
  import slice_mon_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 8,
  parameter  int TS_W     = 16,
  localparam int CHAN_W   = chan_idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      cfg_en,
  input  logic [WIDTH-1:0]          cfg_mask,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [CHAN_W-1:0]         ev_chan,
  output logic [WIDTH-1:0]          ev_value,
  output logic [TS_W-1:0]           ev_time,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [WIDTH-1:0]  value;
    logic [TS_W-1:0]   ts;
  } mon_event_t;

  logic [TS_W-1:0]     ts_count;
  logic [WIDTH-1:0]    prev_q [CHANNELS];
  logic                baseline_armed;
  logic [CHANNELS-1:0] change;
  logic [CHANNELS-1:0] pend_valid;
  logic [WIDTH-1:0]    pend_value [CHANNELS];
  logic [TS_W-1:0]     pend_time [CHANNELS];
  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic [CHANNELS-1:0] coalesce;
  logic                fifo_full;
  logic                can_push;
  mon_event_t          push_data;
  mon_event_t          head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_count       <= '0;
      baseline_armed <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) prev_q[c] <= '0;
    end else begin
      ts_count       <= ts_count + TS_W'(1);
      baseline_armed <= !cfg_en;
      if (cfg_en) begin
        for (int c = 0; c < CHANNELS; c++) prev_q[c] <= in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // The mask is applied combinationally so a mask update acts in the same cycle.
  always_comb begin
    change = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      change[c] = cfg_en && !baseline_armed &&
                  (((in_data[c*WIDTH +: WIDTH] ^ prev_q[c]) & cfg_mask) != '0);
    end
  end

  assign can_push = !fifo_full || (ev_valid && ev_ready);

  // Fixed priority: the lowest-index pending channel wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    push_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (can_push && pend_valid[c] && !grant_any) begin
        grant[c]        = 1'b1;
        grant_any       = 1'b1;
        push_data.chan  = CHAN_W'(c);
        push_data.value = pend_value[c];
        push_data.ts    = pend_time[c];
      end
    end
  end

  always_comb begin
    coalesce = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      coalesce[c] = change[c] && pend_valid[c] && !grant[c];
    end
  end

  // A slot being pushed frees up this cycle, so a simultaneous change reloads it cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        pend_value[c] <= '0;
        pend_time[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (change[c] && (grant[c] || !pend_valid[c])) begin
          pend_valid[c] <= 1'b1;
          pend_value[c] <= in_data[c*WIDTH +: WIDTH];
          pend_time[c]  <= ts_count;
        end else if (change[c]) begin
          pend_value[c] <= in_data[c*WIDTH +: WIDTH];
        end else if (grant[c]) begin
          pend_valid[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (|coalesce) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  event_fifo #(
    .entry_t (mon_event_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_any),
    .push_data (push_data),
    .full      (fifo_full),
    .rd_valid  (ev_valid),
    .rd_ready  (ev_ready),
    .rd_data   (head)
  );

  assign ev_chan  = head.chan;
  assign ev_value = head.value;
  assign ev_time  = head.ts;

endmodule

// File: tb/tb_slice_change_monitor.sv
// Randomised scoreboard bench for slice_change_monitor with a cycle-level reference model.
module tb_slice_change_monitor;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 8;
  localparam int TS_W     = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [CHANNELS*WIDTH-1:0] in_data = '0;
  logic                      cfg_en = 1'b0;
  logic [WIDTH-1:0]          cfg_mask = '0;
  logic                      ev_valid;
  logic                      ev_ready = 1'b0;
  logic [0:0]                ev_chan;
  logic [WIDTH-1:0]          ev_value;
  logic [TS_W-1:0]           ev_time;
  logic                      overflow;
  logic                      ovf_clr = 1'b0;

  slice_change_monitor #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .cfg_en(cfg_en), .cfg_mask(cfg_mask),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan), .ev_value(ev_value),
    .ev_time(ev_time), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int chan;
    int value;
    int ts;
  } exp_ev_t;

  exp_ev_t sb_q[$];
  int  m_cnt;
  bit  m_armed;
  int  m_prev  [CHANNELS];
  bit  m_pv    [CHANNELS];
  int  m_pval  [CHANNELS];
  int  m_ptime [CHANNELS];
  int  m_ts;
  bit  m_ovf;
  int  n_checks = 0;
  int  n_fail = 0;
  int  hs_count = 0;

  function automatic int chanVal(input logic [CHANNELS*WIDTH-1:0] d, input int c);
    return (int'(d) >> (c*WIDTH)) & ((1 << WIDTH) - 1);
  endfunction

  task automatic checkEq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    sb_q.delete();
    m_cnt   = 0;
    m_armed = 1'b1;
    m_ts    = 0;
    m_ovf   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      m_prev[c] = 0; m_pv[c] = 1'b0; m_pval[c] = 0; m_ptime[c] = 0;
    end
  endtask

  // One clock edge of the behavioural model, from the inputs present at that edge.
  task automatic modelStep();
    bit pop, canPush, granted, anyCoal;
    int pushedCh, v;
    bit chg [CHANNELS];
    pop      = (m_cnt > 0) && ev_ready;
    canPush  = (m_cnt < DEPTH) || pop;
    granted  = 1'b0;
    anyCoal  = 1'b0;
    pushedCh = -1;
    for (int c = 0; c < CHANNELS; c++) begin
      v = chanVal(in_data, c);
      chg[c] = cfg_en && !m_armed && (((v ^ m_prev[c]) & int'(cfg_mask)) != 0);
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (!granted && canPush && m_pv[c]) begin
        sb_q.push_back('{c, m_pval[c], m_ptime[c]});
        m_cnt++;
        granted  = 1'b1;
        pushedCh = c;
      end
    end
    if (pop) m_cnt--;
    for (int c = 0; c < CHANNELS; c++) begin
      v = chanVal(in_data, c);
      if (chg[c]) begin
        if (m_pv[c] && pushedCh != c) begin
          m_pval[c] = v;
          anyCoal   = 1'b1;
        end else begin
          m_pv[c] = 1'b1; m_pval[c] = v; m_ptime[c] = m_ts;
        end
      end else if (pushedCh == c) begin
        m_pv[c] = 1'b0;
      end
    end
    if (anyCoal) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (cfg_en) for (int c = 0; c < CHANNELS; c++) m_prev[c] = chanVal(in_data, c);
    m_armed = !cfg_en;
    m_ts    = (m_ts + 1) % (1 << TS_W);
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      if (rst_n) modelStep();
    end
  end

  // Monitor: compares what the DUT presents against the model and the scoreboard.
  task automatic checkOutput();
    exp_ev_t e;
    checkEq("ev_valid", int'(ev_valid), int'(m_cnt > 0));
    checkEq("overflow", int'(overflow), int'(m_ovf));
    if (ev_valid && ev_ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        checkEq("unexpected_event", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkEq("ev_chan", int'(ev_chan), e.chan);
        checkEq("ev_value", int'(ev_value), e.value);
        checkEq("ev_time", int'(ev_time), e.ts);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) checkOutput();
    end
  end

  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] mask,
                               input logic [CHANNELS*WIDTH-1:0] data,
                               input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    cfg_en = en; cfg_mask = mask; in_data = data; ev_ready = rdy; ovf_clr = clr;
  endtask

  task automatic drainAll();
    int i;
    i = 0;
    while (i < 60 && (m_cnt > 0 || m_pv[0] || m_pv[1])) begin
      applyStimulus(1'b0, cfg_mask, in_data, 1'b1, 1'b0);
      i++;
    end
    applyStimulus(1'b0, cfg_mask, in_data, 1'b1, 1'b0);
    applyStimulus(1'b0, cfg_mask, in_data, 1'b1, 1'b0);
    checkEq("drain_scoreboard_empty", sb_q.size(), 0);
  endtask

  initial begin
    int base;
    logic [CHANNELS*WIDTH-1:0] d;
    #1 rst_n = 1'b0;
    modelReset();
    #11;
    checkEq("reset_ev_valid", int'(ev_valid), 0);
    checkEq("reset_ev_chan", int'(ev_chan), 0);
    checkEq("reset_ev_value", int'(ev_value), 0);
    checkEq("reset_ev_time", int'(ev_time), 0);
    checkEq("reset_overflow", int'(overflow), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Baseline suppression: enabling with non-zero data must not produce an event.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'hF, 8'h25, 1'b1, 1'b0);
    checkEq("baseline_no_event", hs_count, 0);

    // Single masked change, then an unmasked-bit change that must be ignored.
    applyStimulus(1'b1, 4'h1, 8'h24, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h1, 8'h24, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h1, 8'h2C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h1, 8'h2C, 1'b1, 1'b0);
    checkEq("single_change_count", hs_count, 1);

    // Simultaneous change on both channels.
    applyStimulus(1'b1, 4'hF, 8'h53, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'hF, 8'h53, 1'b1, 1'b0);
    checkEq("simultaneous_count", hs_count, 3);

    // Backpressure: fill the FIFO, coalesce into the slot, then release.
    for (int i = 0; i < 12; i++) begin
      d = {4'h5, 4'(4 + i)};
      applyStimulus(1'b1, 4'hF, d, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 4'hF, d, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, d, 1'b0, 1'b0);
    #1 checkEq("backpressure_overflow", int'(overflow), 1);
    base = hs_count;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 4'hF, d, 1'b1, 1'b0);
    checkEq("backpressure_event_count", hs_count - base, DEPTH + 1);
    applyStimulus(1'b1, 4'hF, d, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'hF, d, 1'b1, 1'b0);
    #1 checkEq("ovf_clr_overflow", int'(overflow), 0);

    // Randomised traffic with backpressure, mask changes and enable toggles.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), 4'($urandom), 8'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    drainAll();

    // Queue three events, then reset asynchronously mid-cycle.
    applyStimulus(1'b1, 4'hF, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 4'hF, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hF, 8'h03, 1'b0, 1'b0);
    checkEq("queued_before_reset", m_cnt, 3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkEq("async_reset_ev_valid", int'(ev_valid), 0);
    checkEq("async_reset_overflow", int'(overflow), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    base = hs_count;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'hF, 8'h03, 1'b1, 1'b0);
    checkEq("post_reset_no_event", hs_count - base, 0);
    applyStimulus(1'b1, 4'hF, 8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'hF, 8'h07, 1'b1, 1'b0);
    checkEq("post_reset_one_event", hs_count - base, 1);
    drainAll();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/slice_change_monitor.md
# slice_change_monitor

Parametrised multi-channel change monitor. Watches CHANNELS input buses of WIDTH bits each, detects changes in a masked bit-slice, and queues a timestamped event for each change. Events leave through a valid/ready stream. It sits beside the device under observation as a synthesizable replacement for simulation-only `$monitor` tracing, so bit-select change tracking also works in hardware.

## Interface
- WIDTH, 4, bits per channel
- CHANNELS, 2, number of monitored channels (1..16)
- DEPTH, 8, event FIFO entries (power of two, ≥2)
- TS_W, 16, timestamp width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- cfg_en  in  1  monitoring enable
- cfg_mask  in  WIDTH  bit-slice mask, shared by all channels; 1 = bit watched
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_chan  out  max(1,$clog2(CHANNELS))  channel index
- ev_value  out  WIDTH  full channel value after the change
- ev_time  out  TS_W  timestamp of the change
- overflow  out  1  sticky: an event was coalesced or lost
- ovf_clr  in  1  clears overflow

## Operation
- Timestamp counter: free-running. Increments every cycle and wraps from 2^TS_W−1 to 0.
- Per-channel prev register:
  - Loaded with in_data every cycle while cfg_en=1.
  - In the first cycle that cfg_en is 1, after it was 0, prev is loaded as a baseline and no change is flagged.
- Change on channel c: cfg_en=1, not the baseline cycle, and ((in_c ^ prev_c) & cfg_mask) ≠ 0. The mask is applied combinationally, so a mask update takes effect in the same cycle.
- Each channel has one pending slot holding {value, time}.
  - On a change with the slot empty: the slot captures the value and the current timestamp.
  - On a change with the slot already full and not being pushed this cycle: the value is overwritten, the original time is kept, and overflow is set (coalesced).
- Arbiter:
  - Fixed priority, lowest channel index first.
  - Pushes one pending slot per cycle into the FIFO when the FIFO is not full, or is full and a pop occurs in the same cycle.
  - If a channel's slot is pushed and the same channel changes in the same cycle, the old contents are pushed, the slot reloads with the new change, and overflow is not set.
- FIFO:
  - Pop when ev_valid && ev_ready.
  - ev_* outputs are stable while ev_valid=1 && ev_ready=0.
- cfg_en=0: no new detections. Pending slots and the FIFO continue to drain.
- ovf_clr: clears overflow on the next edge. If a new overflow condition occurs in the same cycle, set wins.
- Reset values:
  - ev_valid=0, ev_chan=0, ev_value=0, ev_time=0, overflow=0.
  - Timestamp=0, all pending slots empty, prev=0, FIFO empty.
  - The baseline flag is armed, so the first enabled cycle after reset is a baseline cycle.

## Timing
- Input change sampled in cycle n, with time stamped as T(n).
  - Pending set at edge n.
  - Pushed at edge n+1 if it wins arbitration.
  - ev_valid=1 in cycle n+2.
- Minimum latency is 2 cycles. Throughput is one event per cycle.
- Simultaneous changes on k channels drain over k consecutive cycles, in channel-index order, all carrying the same timestamp.
- Full FIFO with a simultaneous pop: the push proceeds, and the occupancy stays DEPTH.
- Asynchronous reset mid-operation: all state clears immediately. FIFO contents and pending slots are discarded.

## Structure
- Package slice_mon_pkg holds:
  - the event_t struct {chan, value, time};
  - helper functions for the channel-index width and the pointer width.
- Sub-module event_fifo: synchronous FIFO of event_t with valid/ready on the read side and push/full on the write side. It supports push and pop in the same cycle when full.
- Top level contains the timestamp counter, prev and pending registers, baseline flag, arbiter and overflow logic.

## Test plan
- Baseline suppression: reset, set cfg_en=1 with in_data=0x25, and hold it → no event.
- Single change: CHANNELS=2, mask=4'b0001, channel 0 changes 0101→0100 at T=10 → one event {chan 0, value 0100, time 10}, ev_valid rises 2 cycles later. A change 0100→1100 → no event.
- Simultaneous: both channels change at T=20 → channel 0 event, then channel 1 event on consecutive cycles, both with time 20.
- Backpressure and coalesce:
  - ev_ready=0, DEPTH=8, channel 0 changes every cycle → FIFO fills with 8 events.
  - The pending slot then keeps its first time and the latest value, and overflow=1.
  - Release ready → 9 events total, then ovf_clr → overflow=0.
- Full and pop simultaneous: FIFO full, ev_ready=1 while a pending slot exists → pop and push in the same cycle, occupancy stays 8.
- Timestamp wrap and reset: TS_W=4, change at count 15 then at count 0 → times 15 and 0. Assert rst_n=0 with 3 events queued → ev_valid=0 immediately, with no events after release until a post-baseline change.
